// File: rtl/mc_pkg.sv
// Shared definitions for the core-control memory-controller sequencer.
package mc_pkg;

  localparam logic [2:0] COND_IDLE  = 3'b000;
  localparam logic [2:0] COND_STORE = 3'b100;
  localparam logic [2:0] COND_NEXT  = 3'b010;
  localparam logic [2:0] COND_PROC  = 3'b001;
  localparam logic [2:0] COND_NOP   = 3'b011;

  localparam int unsigned TMR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_XFER,
    S_PROC,
    S_NEXT,
    S_ABORT
  } state_t;

  // A batch count of zero still runs one round.
  function automatic logic [3:0] norm_batches(input logic [3:0] b);
    return (b == 4'd0) ? 4'd1 : b;
  endfunction

endpackage

// File: rtl/mc_core_seq_if.sv
// Host config, memory-controller and processing-unit signals of the core sequencer.
interface mc_core_seq_if;
  logic       start;
  logic [5:0] cfg_length;
  logic [3:0] cfg_batches;
  logic       abort;
  logic       mc_done;
  logic       mc_data_done;
  logic       pu_done;
  logic [2:0] mc_data_contition;
  logic [5:0] mc_data_length;
  logic       pu_start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] batch_count;

  modport master (
    input  start, cfg_length, cfg_batches, abort, mc_done, mc_data_done, pu_done,
    output mc_data_contition, mc_data_length, pu_start, busy, done, error, batch_count
  );

  modport slave (
    output start, cfg_length, cfg_batches, abort, mc_done, mc_data_done, pu_done,
    input  mc_data_contition, mc_data_length, pu_start, busy, done, error, batch_count
  );
endinterface

// File: rtl/mc_timeout_cnt.sv
// Loadable down-counter; expired is high once the count reaches zero.
module mc_timeout_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         mc_clk,
  input  logic         mc_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mc_core_seq.sv
// Initiator-side sequencer: store phase, then N transfer/process rounds, with
// timeout and orderly abort back to the memory controller's idle code.
module mc_core_seq
  import mc_pkg::*;
#(
  parameter int unsigned STORE_TIMEOUT = 255,
  parameter int unsigned PROC_TIMEOUT  = 1023
) (
  input logic          mc_clk,
  input logic          mc_reset,
  mc_core_seq_if.master bus
);

  state_t     state_q, state_d;
  logic [2:0] cond_q, cond_d;
  logic [5:0] len_q, len_d;
  logic [3:0] batches_q, batches_d;
  logic       pu_start_q, pu_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [5:0] xfer_q, xfer_d;

  logic [5:0]       xfer_inc;
  logic [3:0]       bcnt_inc;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  assign xfer_inc = (xfer_q == '1) ? xfer_q : xfer_q + 6'd1;
  assign bcnt_inc = bcnt_q + 4'd1;

  // Timer restarts on every state change, with the budget of the state being entered.
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = (state_d == S_PROC) ? TMR_W'(PROC_TIMEOUT - 1) : TMR_W'(STORE_TIMEOUT - 1);

  mc_timeout_cnt #(.W(TMR_W)) u_tmr (
    .mc_clk   (mc_clk),
    .mc_reset (mc_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    len_d      = len_q;
    batches_d  = batches_q;
    pu_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    bcnt_d     = bcnt_q;
    xfer_d     = xfer_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d     = bus.cfg_length;
          batches_d = norm_batches(bus.cfg_batches);
          error_d   = 1'b0;
          bcnt_d    = '0;
          busy_d    = 1'b1;
          cond_d    = COND_STORE;
          state_d   = S_STORE;
        end
      end
      S_STORE: begin
        if (bus.abort) begin
          cond_d  = COND_NEXT;
          state_d = S_ABORT;
        end else if (bus.mc_done) begin
          cond_d  = COND_NOP;
          xfer_d  = '0;
          state_d = S_XFER;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          cond_d  = COND_NEXT;
          state_d = S_ABORT;
        end
      end
      S_XFER: begin
        xfer_d = xfer_inc;
        if (bus.abort) begin
          cond_d  = COND_PROC;
          state_d = S_ABORT;
        end else if (bus.mc_data_done && (xfer_inc > len_q)) begin
          cond_d     = COND_PROC;
          pu_start_d = 1'b1;
          state_d    = S_PROC;
        end
      end
      S_PROC: begin
        if (bus.abort) begin
          cond_d  = COND_IDLE;
          state_d = S_ABORT;
        end else if (bus.pu_done) begin
          bcnt_d = bcnt_inc;
          if (bcnt_inc == batches_q) begin
            cond_d  = COND_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cond_d  = COND_NEXT;
            state_d = S_NEXT;
          end
        end else if (tmr_expired) begin
          error_d = 1'b1;
          cond_d  = COND_IDLE;
          state_d = S_ABORT;
        end
      end
      S_NEXT: begin
        cond_d  = COND_NOP;
        xfer_d  = '0;
        state_d = S_XFER;
      end
      S_ABORT: begin
        // The code currently driven doubles as the drain step: 010 -> 001 -> 000 -> idle.
        case (cond_q)
          COND_NEXT: cond_d = COND_PROC;
          COND_PROC: cond_d = COND_IDLE;
          default: begin
            cond_d  = COND_IDLE;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end
      default: begin
        cond_d  = COND_IDLE;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      state_q    <= S_IDLE;
      cond_q     <= COND_IDLE;
      len_q      <= '0;
      batches_q  <= '0;
      pu_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      bcnt_q     <= '0;
      xfer_q     <= '0;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      len_q      <= len_d;
      batches_q  <= batches_d;
      pu_start_q <= pu_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      bcnt_q     <= bcnt_d;
      xfer_q     <= xfer_d;
    end
  end

  assign bus.mc_data_contition = cond_q;
  assign bus.mc_data_length    = len_q;
  assign bus.pu_start          = pu_start_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.batch_count       = bcnt_q;

endmodule
